// File: rtl/pixel_pad_streamer.sv
// Streams a frame padded with a one-pixel zero border, C words per pixel position.
// Define PAD_STREAMER_FLUSH_EN to append 2*(W+2)*C+4 zero flush beats after each frame.
module pixel_pad_streamer #(
   parameter int DATA_W = 64,
   parameter int DIM_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DIM_W-1:0]  cfg_img_width,
   input  logic [DIM_W-1:0]  cfg_img_height,
   input  logic [9:0]        cfg_ci_groups,
   input  logic              go,
   output logic              busy,
   output logic              done,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_valid,
   output logic              s_ready,
   output logic [DATA_W-1:0] pixel_out,
   output logic              pixel_out_valid,
   output logic              pixel_out_last,
   input  logic              pixel_out_ready
);
   localparam logic [DIM_W:0] ONE = {{DIM_W{1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      IDLE,
      RUN,
`ifdef PAD_STREAMER_FLUSH_EN
      FLUSH,
`endif
      FIN
   } state_t;

   state_t state_q, state_d;

   logic [DIM_W-1:0]  w_q, h_q;
   logic [9:0]        c_q;
   logic              zero_cfg_q;
   logic [DIM_W:0]    row_q, col_q;
   logic [9:0]        grp_q;
   logic              gen_done_q;
   logic [DATA_W-1:0] out_data_q;
   logic              out_valid_q, out_last_q;

   logic [DIM_W:0] row_end, col_end;
   logic [9:0]     grp_end;
   logic           interior, pos_last, out_free, out_fire, run_load;

   // Border rows/columns sit at index 0 and at dimension+1.
   assign row_end  = {1'b0, h_q} + ONE;
   assign col_end  = {1'b0, w_q} + ONE;
   assign grp_end  = c_q - 10'd1;
   assign interior = (row_q != '0) && (row_q != row_end) && (col_q != '0) && (col_q != col_end);
   assign pos_last = (row_q == row_end) && (col_q == col_end) && (grp_q == grp_end);
   assign out_free = !out_valid_q || pixel_out_ready;
   assign out_fire = out_valid_q && pixel_out_ready;

   assign run_load = (state_q == RUN) && !zero_cfg_q && !gen_done_q && out_free &&
                     (!interior || s_valid);
   assign s_ready  = (state_q == RUN) && !zero_cfg_q && !gen_done_q && interior && out_free;

`ifdef PAD_STREAMER_FLUSH_EN
   localparam int FW = DIM_W + 12;
   logic [FW-1:0] flush_total_q, flush_cnt_q, flush_total_d;
   logic          flush_load;

   assign flush_total_d = (((FW'({1'b0, cfg_img_width}) + FW'(2)) * FW'(cfg_ci_groups)) << 1) + FW'(4);
   assign flush_load    = (state_q == FLUSH) && !gen_done_q && out_free;
`endif

   assign busy            = (state_q != IDLE);
   assign done            = (state_q == FIN);
   assign pixel_out       = out_data_q;
   assign pixel_out_valid = out_valid_q;
   assign pixel_out_last  = out_last_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // gen_done_q marks the final beat of the phase as loaded; the phase ends when it is accepted.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (go) state_d = RUN;
         RUN: begin
            if (zero_cfg_q) state_d = FIN;
`ifdef PAD_STREAMER_FLUSH_EN
            else if (gen_done_q && out_fire) state_d = FLUSH;
         end
         FLUSH: begin
            if (gen_done_q && out_fire) state_d = FIN;
`else
            else if (gen_done_q && out_fire) state_d = FIN;
`endif
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         w_q        <= '0;
         h_q        <= '0;
         c_q        <= '0;
         zero_cfg_q <= 1'b0;
`ifdef PAD_STREAMER_FLUSH_EN
         flush_total_q <= '0;
`endif
      end else if (state_q == IDLE && go) begin
         w_q        <= cfg_img_width;
         h_q        <= cfg_img_height;
         c_q        <= cfg_ci_groups;
         zero_cfg_q <= (cfg_img_width == '0) || (cfg_img_height == '0) || (cfg_ci_groups == '0);
`ifdef PAD_STREAMER_FLUSH_EN
         flush_total_q <= flush_total_d;
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row_q      <= '0;
         col_q      <= '0;
         grp_q      <= '0;
         gen_done_q <= 1'b0;
`ifdef PAD_STREAMER_FLUSH_EN
         flush_cnt_q <= '0;
`endif
      end else if (state_q != state_d) begin
         row_q      <= '0;
         col_q      <= '0;
         grp_q      <= '0;
         gen_done_q <= 1'b0;
`ifdef PAD_STREAMER_FLUSH_EN
         flush_cnt_q <= '0;
`endif
      end else if (run_load) begin
         if (pos_last) gen_done_q <= 1'b1;
         if (grp_q == grp_end) begin
            grp_q <= '0;
            if (col_q == col_end) begin
               col_q <= '0;
               row_q <= row_q + ONE;
            end else begin
               col_q <= col_q + ONE;
            end
         end else begin
            grp_q <= grp_q + 10'd1;
         end
`ifdef PAD_STREAMER_FLUSH_EN
      end else if (flush_load) begin
         flush_cnt_q <= flush_cnt_q + FW'(1);
         if (flush_cnt_q == flush_total_q - FW'(1)) gen_done_q <= 1'b1;
`endif
      end
   end

   // Single output register: loads only when empty or draining, so it holds while stalled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
      end else if (run_load) begin
         out_data_q  <= interior ? s_data : '0;
         out_valid_q <= 1'b1;
         out_last_q  <= pos_last;
`ifdef PAD_STREAMER_FLUSH_EN
      end else if (flush_load) begin
         out_data_q  <= '0;
         out_valid_q <= 1'b1;
         out_last_q  <= 1'b0;
`endif
      end else if (out_fire) begin
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
      end
   end

endmodule

// File: doc/pixel_pad_streamer.md
PIXEL_PAD_STREAMER -- requirements
Module: pixel_pad_streamer

Interface
REQ-001 SHALL have parameter DATA_W, default 64, meaning the pixel word width (8 channels x int8).
REQ-002 SHALL have parameter DIM_W, default 16, meaning the width of the dimension configuration fields.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst  input  1  meaning the reset, asynchronous and active-high.
REQ-005 SHALL have port cfg_img_width  input  DIM_W  meaning the unpadded image width W.
REQ-006 SHALL have port cfg_img_height  input  DIM_W  meaning the unpadded image height H.
REQ-007 SHALL have port cfg_ci_groups  input  10  meaning the number of 8-channel input groups per pixel (C).
REQ-008 SHALL have port go  input  1  meaning a one-cycle start pulse.
REQ-009 SHALL have ports busy and done  output  1 each  meaning frame in progress and a one-cycle completion pulse.
REQ-010 SHALL have ports s_data (input, DATA_W), s_valid (input, 1) and s_ready (output, 1), meaning the unpadded input stream.
REQ-011 SHALL have ports pixel_out (output, DATA_W), pixel_out_valid (output, 1), pixel_out_last (output, 1) and pixel_out_ready (input, 1), meaning the padded stream to conv_top.

Function
REQ-012 SHALL latch W, H and C on go while in IDLE; go SHALL be ignored in all other states.
REQ-013 SHALL use FSM states IDLE, RUN, FLUSH and FIN.
- IDLE to RUN on go.
- RUN to FLUSH after the last beat is accepted (FIN instead when the macro is absent).
- FLUSH to FIN after the last flush beat is accepted.
- FIN to IDLE after one cycle, with done=1 for that cycle.
REQ-014 SHALL emit the padded frame in row-major order over (H+2) rows x (W+2) columns, with C consecutive words per position (group index innermost), for a total of (H+2)*(W+2)*C beats.
REQ-015 SHALL treat a position as border when the row is 0 or H+1, or the column is 0 or W+1; border positions SHALL emit all-zero words and SHALL hold s_ready=0.
REQ-016 SHALL pass interior words unmodified from s_data, consuming exactly one input word per interior output beat, for H*W*C input words in total.
REQ-017 SHALL register outputs with one-cycle latency from input acceptance (s_valid and s_ready) to pixel_out_valid.
REQ-018 SHALL hold pixel_out, pixel_out_valid and pixel_out_last stable while pixel_out_valid=1 and pixel_out_ready=0; counters SHALL advance only on an accepted beat.
REQ-019 SHALL drive s_ready=1 only in RUN, at an interior position, when the output register is empty or being accepted in the same cycle.
REQ-020 SHALL assert pixel_out_last only on beat (H+2)*(W+2)*C-1 of the frame.
REQ-021 SHALL hold busy=1 in RUN, FLUSH and FIN, and busy=0 in IDLE.
REQ-022 SHALL, when W, H or C is zero at go, emit no beats and pulse done on the second cycle after go.
REQ-023 SHALL size its position counters to DIM_W+1 bits so that W+2 and H+2 do not wrap at the maximum configuration.

Reset
REQ-024 SHALL, on rst=1 at any time including mid-frame, immediately enter IDLE and drive busy=0, done=0, s_ready=0, pixel_out_valid=0, pixel_out_last=0, pixel_out=0, and clear all counters.
REQ-025 SHALL discard any partially streamed frame on reset; the next frame SHALL start from row 0 after a new go.

Configuration
REQ-026 SHALL, when macro PAD_STREAMER_FLUSH_EN is defined, emit 2*(W+2)*C+4 all-zero beats in FLUSH after the frame, with pixel_out_valid=1 and pixel_out_last=0, honouring pixel_out_ready.
REQ-027 SHALL, when PAD_STREAMER_FLUSH_EN is not defined, contain no FLUSH state or logic and go directly to FIN after the last beat.

Verification
REQ-028 SHALL cover this scenario: W=4, H=4, C=2, pixel_out_ready=1, s_valid=1 with inputs 1..32 -> 72 beats; beats 0-13 are zero; beat 14 = 1; beat 15 = 2; pixel_out_last is set only on beat 71; done pulses once.
REQ-029 SHALL cover this scenario: W=1, H=1, C=1, input 0xAA -> 9 beats; only beat 4 = 0xAA; s_ready is high for exactly one accepted cycle.
REQ-030 SHALL cover this scenario: the 4x4x2 case with pixel_out_ready toggling 1-0-1 -> pixel_out is held stable while stalled; the beat sequence is identical to the unstalled run; no input word is lost or duplicated.
REQ-031 SHALL cover this scenario: the 4x4x2 case with s_valid low every other cycle -> the output matches the unstalled sequence, and border beats are still emitted without waiting on s_valid.
REQ-032 SHALL cover this scenario: rst asserted at beat 30, then a new go -> outputs are zero on the reset cycle; the next frame starts with 14 zero beats.
REQ-033 SHALL cover this scenario: PAD_STREAMER_FLUSH_EN defined, 4x4x2 -> 28 zero flush beats follow the last beat, then the done pulse; with the macro undefined, done follows the last beat directly.
